spicart_host: RTL and testbench
===============================

# spicart_host

SPI initiator for the spicart cart-access protocol. It issues one cart read or write per request, over the same four-wire link that spicart answers on the responder side. It lets on-FPGA logic or a loopback bench drive spicart without the Raspberry Pi. It sits beside spicart and, for loopback, wires spi_sck/spi_mosi/spi_cs to spicart's inputs and spi_miso to its output.

## Interface
Parameters:
- CLK_DIV, default 4: SCK half-period in clk_8m cycles (D). Legal range 2..255.

Ports:
- clk_8m  in  1  system clock; the only clock.
- nrst  in  1  asynchronous, active-low reset.
- req  in  1  start a transaction; sampled only while busy=0.
- we  in  1  1 = write, 0 = read; captured with req.
- addr  in  16  cart address; captured with req.
- wdata  in  8  write data; captured with req.
- busy  out  1  transaction or CS-high gap in progress.
- done  out  1  one-cycle pulse at transaction end.
- rdata  out  8  read result; valid from done, held until the next read's done.
- spi_sck  out  1  SPI clock, mode 0, idle low.
- spi_mosi  out  1  data to responder, MSB first.
- spi_miso  in  1  data from responder.
- spi_cs  out  1  chip select, active low, idle high.

## Operation
- Frames:
  - Write: CMD_WR, addr[15:8], addr[7:0], wdata. 4 bytes, N=32 bits.
  - Read: CMD_RD, addr[15:8], addr[7:0], DUMMY, then 8 more clocks shifting out DUMMY while capturing rdata. 5 bytes, N=40 bits.
  - The DUMMY byte gives spicart time for its cart_iface access.
- Bytes are sent back-to-back with no gap inside a frame.
- FSM states: IDLE, SETUP, SHIFT, HOLD, GAP.
  - IDLE → SETUP: when req=1. Latch we/addr/wdata, assert busy, drive spi_cs low, put bit 7 of the command on MOSI.
  - SETUP → SHIFT: after D cycles.
  - SHIFT: SCK high for D cycles, then low for D cycles, per bit. MOSI updates on the falling edge. MISO is sampled in the last high-phase cycle. After bit N−1 falls, go to HOLD.
  - HOLD → GAP: after D cycles with SCK low. spi_cs goes high and done pulses in that same cycle; rdata is updated for reads.
  - GAP → IDLE: after D cycles; busy falls.
- req while busy=1 is ignored; it is not queued.
- Write frames leave rdata unchanged.
- A bit counter of 6 bits and a 40-bit shift register are sufficient. MOSI is taken from the shift register MSB.

## Timing
- Reset values: busy=0, done=0, rdata=8'h00, spi_sck=0, spi_mosi=0, spi_cs=1, state IDLE.
- nrst low mid-frame: all outputs take their reset values asynchronously, spi_cs rises immediately, and the transaction is abandoned with no done pulse.
- Cycle numbering: req accepted at cycle 0.
  - spi_cs falls at cycle 1.
  - Bit k: SCK rises at 1+D+2Dk and falls at 1+2D+2Dk.
  - done and spi_cs rise at 1+2DN+D.
  - busy falls at 1+2DN+2D.
- With D=4:
  - Read: done at cycle 325, busy low at 329.
  - Write: done at cycle 261, busy low at 265.
- req held high continuously: a new transaction starts in the first cycle busy=0. CS-high time between frames is therefore exactly D+1 cycles.
- addr=16'hFFFF and D=2 are legal; there is no wrap or overflow behaviour.

## Structure
- Shared package dmgplus_pkg holds:
  - SPICART_CMD_RD = 8'h01
  - SPICART_CMD_WR = 8'h02
  - SPICART_DUMMY = 8'h00
  - the FSM state enum
- spicart uses the same constants; they must not be duplicated locally.
- One natural sub-module: spi_sck_gen. It is the D-cycle phase counter emitting rise and fall strobes, and is enabled only in SHIFT.

## Test plan
- Write, D=4, addr=16'h2000, wdata=8'h05: MOSI bytes are 02 20 00 05, done at cycle 261, rdata unchanged.
- Read, D=4, addr=16'h0134, MISO model returns 8'hA5 in the last byte: MOSI bytes are 01 01 34 00 00, rdata=8'hA5 at done (cycle 325).
- Loopback to spicart with a cart model: write 8'h3C to 16'hA000, then read 16'hA000 → rdata=8'h3C.
- req held high for 3 writes, D=2: three frames, each CS-high gap exactly 3 cycles, three done pulses.
- nrst asserted at cycle 100 of a read: spi_cs=1 and busy=0 the same cycle, no done pulse. A following read completes normally.
- req pulsed while busy: ignored, no extra frame, and SCK rises at exactly 8 cycles per bit at D=4.

Source files
------------

// File: rtl/dmgplus_pkg.sv
// Constants and types shared between the spicart responder and the spicart_host initiator.
package dmgplus_pkg;

  localparam logic [7:0] SPICART_CMD_RD = 8'h01;
  localparam logic [7:0] SPICART_CMD_WR = 8'h02;
  localparam logic [7:0] SPICART_DUMMY  = 8'h00;

  typedef enum logic [2:0] {
    HOST_IDLE  = 3'd0,
    HOST_SETUP = 3'd1,
    HOST_SHIFT = 3'd2,
    HOST_HOLD  = 3'd3,
    HOST_GAP   = 3'd4
  } spicart_host_state_e;

  // Left-aligned 40-bit frame; a write only uses the top 32 bits.
  function automatic logic [39:0] spicart_frame(input logic we, input logic [15:0] addr,
                                                input logic [7:0] wdata);
    return we ? {SPICART_CMD_WR, addr, wdata, SPICART_DUMMY}
              : {SPICART_CMD_RD, addr, SPICART_DUMMY, SPICART_DUMMY};
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SCK phase counter: CLK_DIV cycles per phase, starting in the high phase when enabled.
module spi_sck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_8m,
  input  logic nrst,
  input  logic en,
  output logic rise,
  output logic fall
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt_reg;
  logic       high_reg;

  always_ff @(posedge clk_8m or negedge nrst) begin
    if (!nrst) begin
      cnt_reg  <= '0;
      high_reg <= 1'b1;
    end else if (!en) begin
      cnt_reg  <= '0;
      high_reg <= 1'b1;
    end else if (cnt_reg == DIV_LAST) begin
      cnt_reg  <= '0;
      high_reg <= ~high_reg;
    end else begin
      cnt_reg <= cnt_reg + 8'd1;
    end
  end

  // Strobes mark the last cycle of a phase; the SCK register flips on the next edge.
  assign rise = en && (cnt_reg == DIV_LAST) && !high_reg;
  assign fall = en && (cnt_reg == DIV_LAST) && high_reg;

endmodule

// File: rtl/spicart_host.sv
// SPI mode-0 initiator issuing one spicart cart read or write frame per request.
module spicart_host
  import dmgplus_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic        clk_8m,
  input  logic        nrst,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic        busy,
  output logic        done,
  output logic [7:0]  rdata,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        spi_cs
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  spicart_host_state_e state_reg;
  logic [7:0]          wait_cnt_reg;
  logic [5:0]          bit_cnt_reg;
  logic [5:0]          last_bit_reg;
  logic [39:0]         shift_reg;
  logic                we_reg;
  logic                busy_reg;
  logic                done_reg;
  logic [7:0]          rdata_reg;
  logic                sck_reg;
  logic                cs_reg;
  logic                sck_rise;
  logic                sck_fall;
  logic                wait_last;

  assign wait_last = (wait_cnt_reg == DIV_LAST);

  spi_sck_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sck_gen (
    .clk_8m(clk_8m),
    .nrst  (nrst),
    .en    (state_reg == HOST_SHIFT),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  always_ff @(posedge clk_8m or negedge nrst) begin
    if (!nrst) begin
      state_reg    <= HOST_IDLE;
      wait_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      last_bit_reg <= '0;
      shift_reg    <= '0;
      we_reg       <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      rdata_reg    <= 8'h00;
      sck_reg      <= 1'b0;
      cs_reg       <= 1'b1;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        HOST_IDLE: begin
          wait_cnt_reg <= '0;
          if (req) begin
            we_reg       <= we;
            shift_reg    <= spicart_frame(we, addr, wdata);
            last_bit_reg <= we ? 6'd31 : 6'd39;
            bit_cnt_reg  <= '0;
            busy_reg     <= 1'b1;
            cs_reg       <= 1'b0;
            state_reg    <= HOST_SETUP;
          end
        end
        HOST_SETUP: begin
          if (wait_last) begin
            wait_cnt_reg <= '0;
            sck_reg      <= 1'b1;
            state_reg    <= HOST_SHIFT;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
          end
        end
        HOST_SHIFT: begin
          if (sck_rise) sck_reg <= 1'b1;
          // MISO is captured in the last high cycle, MOSI advances as SCK falls.
          if (sck_fall) begin
            sck_reg   <= 1'b0;
            shift_reg <= {shift_reg[38:0], spi_miso};
            if (bit_cnt_reg == last_bit_reg) state_reg <= HOST_HOLD;
            else bit_cnt_reg <= bit_cnt_reg + 6'd1;
          end
        end
        HOST_HOLD: begin
          if (wait_last) begin
            wait_cnt_reg <= '0;
            cs_reg       <= 1'b1;
            done_reg     <= 1'b1;
            if (!we_reg) rdata_reg <= shift_reg[7:0];
            state_reg    <= HOST_GAP;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
          end
        end
        HOST_GAP: begin
          if (wait_last) begin
            wait_cnt_reg <= '0;
            busy_reg     <= 1'b0;
            state_reg    <= HOST_IDLE;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
          end
        end
        default: state_reg <= HOST_IDLE;
      endcase
    end
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign rdata    = rdata_reg;
  assign spi_sck  = sck_reg;
  assign spi_cs   = cs_reg;
  assign spi_mosi = shift_reg[39] & ~cs_reg;

endmodule

// File: tb/tb_spicart_host.sv
// Scoreboard bench for spicart_host with a behavioural spicart responder and cart memory.
module tb_spicart_host;
  import dmgplus_pkg::*;

  typedef struct {
    int          start;
    int          lat;
    logic [7:0]  rdata;
    logic [39:0] frame;
    int          nbits;
  } exp_t;

  logic clk_8m = 1'b0;
  always #5 clk_8m = ~clk_8m;

  int cyc = 0;
  always @(posedge clk_8m) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // DUT a: CLK_DIV=4, attached to the responder model
  logic        a_nrst = 1'b0, a_req = 1'b0, a_we = 1'b0;
  logic [15:0] a_addr = '0;
  logic [7:0]  a_wdata = '0;
  logic        a_busy, a_done, a_sck, a_mosi, a_cs;
  logic        a_miso = 1'b0;
  logic [7:0]  a_rdata;

  // DUT b: CLK_DIV=2, back-to-back writes
  logic        b_nrst = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [15:0] b_addr = '0;
  logic [7:0]  b_wdata = '0;
  logic        b_busy, b_done, b_sck, b_mosi, b_cs;
  logic        b_miso = 1'b0;
  logic [7:0]  b_rdata;

  spicart_host #(.CLK_DIV(4)) dut_a (
    .clk_8m(clk_8m), .nrst(a_nrst), .req(a_req), .we(a_we), .addr(a_addr), .wdata(a_wdata),
    .busy(a_busy), .done(a_done), .rdata(a_rdata), .spi_sck(a_sck), .spi_mosi(a_mosi),
    .spi_miso(a_miso), .spi_cs(a_cs)
  );

  spicart_host #(.CLK_DIV(2)) dut_b (
    .clk_8m(clk_8m), .nrst(b_nrst), .req(b_req), .we(b_we), .addr(b_addr), .wdata(b_wdata),
    .busy(b_busy), .done(b_done), .rdata(b_rdata), .spi_sck(b_sck), .spi_mosi(b_mosi),
    .spi_miso(b_miso), .spi_cs(b_cs)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Responder: shifts MOSI in on rising SCK, drives MISO on falling SCK.
  logic [7:0]  mem [0:65535];
  logic [39:0] rx_sh = '0;
  int          rx_cnt = 0;
  logic [7:0]  tx_sh = '0;

  always @(negedge a_cs) begin
    rx_sh  = '0;
    rx_cnt = 0;
    tx_sh  = '0;
    a_miso = 1'b0;
  end

  always @(posedge a_sck) begin
    if (!a_cs) begin
      rx_sh  = {rx_sh[38:0], a_mosi};
      rx_cnt = rx_cnt + 1;
    end
  end

  always @(negedge a_sck) begin
    if (!a_cs) begin
      if (rx_cnt == 32 && rx_sh[31:24] == SPICART_CMD_RD) tx_sh = mem[rx_sh[23:8]];
      else tx_sh = {tx_sh[6:0], 1'b0};
      a_miso = tx_sh[7];
    end
  end

  always @(posedge a_cs) begin
    if (rx_cnt == 32 && rx_sh[31:24] == SPICART_CMD_WR) mem[rx_sh[23:8]] = rx_sh[7:0];
  end

  // Scoreboard monitors
  exp_t a_q[$], b_q[$];
  exp_t a_e, b_e;

  always @(negedge clk_8m) begin
    if (a_done) begin
      if (a_q.size() == 0) begin
        chk("a_unexpected_done", 1, 0);
      end else begin
        a_e = a_q.pop_front();
        chk("a_done_cycle", cyc - a_e.start, a_e.lat);
        chk("a_rdata", a_rdata, a_e.rdata);
        chk("a_mosi_frame", rx_sh, a_e.frame);
        chk("a_frame_bits", rx_cnt, a_e.nbits);
        $display("txn a: done at +%0d rdata=%02h frame=%010h bits=%0d",
                 cyc - a_e.start, a_rdata, rx_sh, rx_cnt);
      end
    end
  end

  always @(negedge clk_8m) begin
    if (b_done) begin
      if (b_q.size() == 0) begin
        chk("b_unexpected_done", 1, 0);
      end else begin
        b_e = b_q.pop_front();
        chk("b_done_cycle", cyc - b_e.start, b_e.lat);
        chk("b_rdata", b_rdata, b_e.rdata);
        $display("txn b: done at +%0d rdata=%02h", cyc - b_e.start, b_rdata);
      end
    end
  end

  // SCK cadence on DUT a: first rise D cycles after CS falls, then one rise per 2D cycles.
  logic a_sck_prev = 1'b0, a_cs_prev = 1'b1, a_first = 1'b1;
  int   a_cs_fall_cyc = 0, a_last_rise = 0;
  always @(negedge clk_8m) begin
    if (a_cs_prev && !a_cs) begin
      a_cs_fall_cyc = cyc;
      a_first       = 1'b1;
    end
    if (!a_sck_prev && a_sck && !a_cs) begin
      if (a_first) chk("a_first_rise", cyc - a_cs_fall_cyc, 4);
      else chk("a_rise_period", cyc - a_last_rise, 8);
      a_last_rise = cyc;
      a_first     = 1'b0;
    end
    a_sck_prev = a_sck;
    a_cs_prev  = a_cs;
  end

  // CS-high gap between back-to-back frames on DUT b
  logic b_cs_prev = 1'b1;
  int   b_high_run = 0, b_frames = 0;
  always @(negedge clk_8m) begin
    if (b_cs) begin
      b_high_run++;
    end else begin
      if (b_cs_prev) begin
        if (b_frames > 0) chk("b_cs_gap", b_high_run, 3);
        b_frames++;
      end
      b_high_run = 0;
    end
    b_cs_prev = b_cs;
  end

  task automatic a_wait_idle(input int start, input int lat);
    int n = 0;
    while (a_busy && n < 1000) begin
      @(negedge clk_8m);
      n++;
    end
    if (a_busy) chk("a_busy_timeout", 1, 0);
    else chk("a_busy_fall", cyc - start, lat);
  endtask

  task automatic a_txn(input logic t_we, input logic [15:0] t_addr, input logic [7:0] t_wdata,
                       input logic [7:0] exp_rdata, input logic [39:0] exp_frame,
                       input int pulse_at);
    exp_t e;
    int   start;
    @(posedge clk_8m); #1;
    start   = cyc;
    e.start = start;
    e.lat   = t_we ? 261 : 325;
    e.rdata = exp_rdata;
    e.frame = exp_frame;
    e.nbits = t_we ? 32 : 40;
    a_q.push_back(e);
    a_we = t_we; a_addr = t_addr; a_wdata = t_wdata; a_req = 1'b1;
    @(posedge clk_8m); #1;
    a_req = 1'b0;
    if (pulse_at > 0) begin
      while (cyc < start + pulse_at) begin
        @(posedge clk_8m); #1;
      end
      a_we = 1'b1; a_addr = 16'hA000; a_wdata = 8'hFF; a_req = 1'b1;
      @(posedge clk_8m); #1;
      a_req = 1'b0;
    end
    a_wait_idle(start, t_we ? 265 : 329);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    int n;
    exp_t e;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0134] = 8'hA5;

    repeat (3) @(negedge clk_8m);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_rdata", a_rdata, 8'h00);
    chk("rst_sck", a_sck, 0);
    chk("rst_mosi", a_mosi, 0);
    chk("rst_cs", a_cs, 1);
    chk("rst_b_cs", b_cs, 1);
    @(posedge clk_8m); #1;
    a_nrst = 1'b1;
    b_nrst = 1'b1;

    a_txn(1'b1, 16'h2000, 8'h05, 8'h00, 40'h00_0220_0005, 0);
    a_txn(1'b0, 16'h0134, 8'h00, 8'hA5, 40'h01_0134_0000, 0);
    a_txn(1'b1, 16'hA000, 8'h3C, 8'hA5, 40'h00_02A0_003C, 0);
    a_txn(1'b0, 16'hA000, 8'h00, 8'h3C, 40'h01_A000_0000, 0);

    // Reset at cycle 100 of a read: outputs drop immediately, no done.
    @(posedge clk_8m); #1;
    start = cyc;
    a_we = 1'b0; a_addr = 16'h0134; a_req = 1'b1;
    @(posedge clk_8m); #1;
    a_req = 1'b0;
    while (cyc < start + 100) begin
      @(posedge clk_8m); #1;
    end
    chk("pre_rst_busy", a_busy, 1);
    a_nrst = 1'b0;
    #1;
    chk("mid_rst_cs", a_cs, 1);
    chk("mid_rst_busy", a_busy, 0);
    chk("mid_rst_sck", a_sck, 0);
    chk("mid_rst_rdata", a_rdata, 8'h00);
    repeat (2) @(posedge clk_8m);
    #1;
    a_nrst = 1'b1;
    repeat (400) @(negedge clk_8m);

    a_txn(1'b0, 16'h0134, 8'h00, 8'hA5, 40'h01_0134_0000, 0);
    // req pulsed mid-frame must be ignored, leaving 16'hA000 untouched.
    a_txn(1'b0, 16'hA000, 8'h00, 8'h3C, 40'h01_A000_0000, 50);
    repeat (20) @(negedge clk_8m);
    a_txn(1'b0, 16'hA000, 8'h00, 8'h3C, 40'h01_A000_0000, 0);

    // DUT b: req held high for three writes at D=2 (period 133 cycles).
    @(posedge clk_8m); #1;
    start = cyc;
    for (int k = 0; k < 3; k++) begin
      e.start = start;
      e.lat   = 131 + 133 * k;
      e.rdata = 8'h00;
      e.frame = '0;
      e.nbits = 32;
      b_q.push_back(e);
    end
    b_we = 1'b1; b_addr = 16'hFFFF; b_wdata = 8'h5A; b_req = 1'b1;
    while (cyc < start + 300) begin
      @(posedge clk_8m); #1;
    end
    b_req = 1'b0;
    n = 0;
    while ((b_busy || b_q.size() != 0) && n < 1000) begin
      @(negedge clk_8m);
      n++;
    end
    chk("b_drain", b_q.size(), 0);
    chk("b_busy_end", b_busy, 0);
    repeat (20) @(negedge clk_8m);
    chk("b_frames", b_frames, 3);

    chk("a_queue_empty", a_q.size(), 0);
    chk("b_queue_empty", b_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
